// File: rtl/snd_sequencer.sv
`timescale 1ns/1ps
// snd_sequencer
// Plays queued song requests back to back from an internal song ROM and
// drives the 4-bit note code of the piezo driver (0 = silence).
//
// Each note is held for (dur+1)*UNIT_CYCLES clocks. An optional silent gap
// of GAP_CYCLES clocks follows every note. Priority requests flush the queue
// and abort the current song. Song 0 is a stop command.
//
// Note codes: 1=C4 2=D4 3=E4 4=F4 5=G4 6=A4 7=B4 8=C5, 0=rest/silence.
//
// Ports
//   clk_1mhz    clock
//   rst         asynchronous, active-high reset
//   req_valid   song request strobe, one request per cycle
//   req_song    requested song id (0 = stop)
//   req_prio    1 = pre-empt: flush queue, abort current song, play now
//   req_ready   queue not full (priority/stop requests are always taken)
//   note_out    registered note code to the piezo driver
//   playing     high from the first note of a song until its end or abort
//   done_pulse  one-clock pulse when a song completes naturally
//   drop_pulse  one-clock pulse when a normal request hits a full queue
//   q_count     queue occupancy
module snd_sequencer #(
  parameter int unsigned UNIT_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES  = 10000,
  parameter int unsigned SONG_W      = 3,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic                      clk_1mhz,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [SONG_W-1:0]         req_song,
  input  logic                      req_prio,
  output logic                      req_ready,
  output logic [3:0]                note_out,
  output logic                      playing,
  output logic                      done_pulse,
  output logic                      drop_pulse,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned PTR_W   = $clog2(QDEPTH);
  localparam int unsigned CNT_MAX = (4 * UNIT_CYCLES > GAP_CYCLES) ? 4 * UNIT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PLAY_LAST0 = CNT_W'(1 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLAY_LAST1 = CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLAY_LAST2 = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLAY_LAST3 = CNT_W'(4 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(MAX_LEN - 1);

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D4   = 4'd2;
  localparam logic [3:0] NOTE_E4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_G4   = 4'd5;
  localparam logic [3:0] NOTE_A4   = 4'd6;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  // ROM word layout: {last, note[3:0], dur[1:0]}
  function automatic logic [6:0] ent(input logic last, input logic [3:0] note,
                                     input logic [1:0] dur);
    return {last, note, dur};
  endfunction

  function automatic logic [6:0] rom_entry(input logic [SONG_W-1:0] song,
                                           input logic [IDX_W-1:0] idx);
    int unsigned s;
    int unsigned i;
    logic [6:0]  w;
    s = 32'(song);
    i = 32'(idx);
    // Unused ids and out-of-range indices read as a silent final unit.
    w = ent(1'b1, NOTE_REST, 2'd0);
    case (s)
      1: case (i)
           0: w = ent(1'b1, NOTE_D4, 2'd0);
           default: w = ent(1'b1, NOTE_REST, 2'd0);
         endcase
      2: case (i)
           0: w = ent(1'b1, NOTE_C5, 2'd1);
           default: w = ent(1'b1, NOTE_REST, 2'd0);
         endcase
      3: case (i)
           0: w = ent(1'b0, NOTE_C4, 2'd0);
           1: w = ent(1'b1, NOTE_G4, 2'd0);
           default: w = ent(1'b1, NOTE_REST, 2'd0);
         endcase
      4: case (i)
           0: w = ent(1'b0, NOTE_E4, 2'd0);
           1: w = ent(1'b0, NOTE_REST, 2'd0);
           2: w = ent(1'b1, NOTE_E4, 2'd0);
           default: w = ent(1'b1, NOTE_REST, 2'd0);
         endcase
      5: case (i)
           0: w = ent(1'b0, NOTE_C4, 2'd0);
           1: w = ent(1'b0, NOTE_E4, 2'd0);
           2: w = ent(1'b0, NOTE_G4, 2'd0);
           3: w = ent(1'b1, NOTE_C5, 2'd1);
           default: w = ent(1'b1, NOTE_REST, 2'd0);
         endcase
      6: case (i)
           0: w = ent(1'b0, NOTE_C5, 2'd0);
           1: w = ent(1'b0, NOTE_G4, 2'd0);
           2: w = ent(1'b0, NOTE_E4, 2'd0);
           3: w = ent(1'b1, NOTE_C4, 2'd2);
           default: w = ent(1'b1, NOTE_REST, 2'd0);
         endcase
      7: case (i)
           0: w = ent(1'b0, NOTE_C4, 2'd0);
           1: w = ent(1'b0, NOTE_E4, 2'd0);
           2: w = ent(1'b0, NOTE_G4, 2'd0);
           3: w = ent(1'b0, NOTE_REST, 2'd0);
           4: w = ent(1'b0, NOTE_F4, 2'd0);
           5: w = ent(1'b0, NOTE_A4, 2'd0);
           6: w = ent(1'b1, NOTE_C5, 2'd3);
           default: w = ent(1'b1, NOTE_REST, 2'd0);
         endcase
      default: w = ent(1'b1, NOTE_REST, 2'd0);
    endcase
    return w;
  endfunction

  // Registers
  state_t              state_reg, state_next;
  logic [SONG_W-1:0]   song_reg, song_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                last_reg, last_next;
  logic [1:0]          dur_reg, dur_next;
  logic [3:0]          note_reg, note_next;
  logic                playing_reg, playing_next;
  logic                done_reg, done_next;
  logic                drop_reg, drop_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]      count_reg, count_next;

  logic [SONG_W-1:0]   fifo_mem [QDEPTH];

  // Request decode
  logic                fifo_full, fifo_empty;
  logic                req_stop, req_pre, req_norm;
  logic                push, pop, flush, end_note;
  logic [6:0]          rom_word;
  logic [CNT_W-1:0]    play_last;
  logic [SONG_W-1:0]   fifo_head;

  assign fifo_full  = (count_reg == (PTR_W+1)'(QDEPTH));
  assign fifo_empty = (count_reg == '0);
  assign fifo_head  = fifo_mem[rd_ptr_reg];

  assign req_stop = req_valid && (req_song == '0);
  assign req_pre  = req_valid && req_prio && (req_song != '0);
  assign req_norm = req_valid && !req_prio && (req_song != '0);
  assign push     = req_norm && !fifo_full;

  assign rom_word = rom_entry(song_reg, idx_reg);

  always_comb begin
    case (dur_reg)
      2'd0:    play_last = PLAY_LAST0;
      2'd1:    play_last = PLAY_LAST1;
      2'd2:    play_last = PLAY_LAST2;
      default: play_last = PLAY_LAST3;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    song_next    = song_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    last_next    = last_reg;
    dur_next     = dur_reg;
    note_next    = note_reg;
    playing_next = playing_reg;
    done_next    = 1'b0;
    drop_next    = req_norm && fifo_full;
    pop          = 1'b0;
    flush        = 1'b0;
    end_note     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          song_next  = fifo_head;
          idx_next   = '0;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        last_next    = rom_word[6];
        note_next    = rom_word[5:2];
        dur_next     = rom_word[1:0];
        playing_next = 1'b1;
        cnt_next     = '0;
        state_next   = S_PLAY;
      end
      S_PLAY: begin
        if (cnt_reg == play_last) begin
          cnt_next = '0;
          if (GAP_CYCLES > 0) begin
            note_next  = NOTE_REST;
            state_next = S_GAP;
          end else begin
            end_note = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          end_note = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // The index guard ends a song that has no last flag within MAX_LEN
    // entries instead of wrapping back to its first note.
    if (end_note) begin
      if (!last_reg && (idx_reg != IDX_LAST)) begin
        idx_next   = idx_reg + 1'b1;
        state_next = S_LOAD;
      end else begin
        done_next    = 1'b1;
        playing_next = 1'b0;
        note_next    = NOTE_REST;
        if (!fifo_empty) begin
          // Chain straight into the next queued song.
          pop        = 1'b1;
          song_next  = fifo_head;
          idx_next   = '0;
          state_next = S_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
    end

    // Stop and priority requests override whatever the sequencer decided;
    // a done_pulse already raised for a song finishing this clock survives.
    if (req_stop) begin
      flush        = 1'b1;
      pop          = 1'b0;
      note_next    = NOTE_REST;
      playing_next = 1'b0;
      idx_next     = '0;
      cnt_next     = '0;
      state_next   = S_IDLE;
    end else if (req_pre) begin
      flush        = 1'b1;
      pop          = 1'b0;
      song_next    = req_song;
      note_next    = NOTE_REST;
      playing_next = 1'b0;
      idx_next     = '0;
      cnt_next     = '0;
      state_next   = S_LOAD;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      song_reg    <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      last_reg    <= 1'b0;
      dur_reg     <= '0;
      note_reg    <= NOTE_REST;
      playing_reg <= 1'b0;
      done_reg    <= 1'b0;
      drop_reg    <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      song_reg    <= song_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      last_reg    <= last_next;
      dur_reg     <= dur_next;
      note_reg    <= note_next;
      playing_reg <= playing_next;
      done_reg    <= done_next;
      drop_reg    <= drop_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_1mhz) begin
    if (push) fifo_mem[wr_ptr_reg] <= req_song;
  end

  assign req_ready  = !fifo_full;
  assign note_out   = note_reg;
  assign playing    = playing_reg;
  assign done_pulse = done_reg;
  assign drop_pulse = drop_reg;
  assign q_count    = count_reg;

endmodule

// File: tb/tb_snd_sequencer.sv
`timescale 1ns/1ps
module tb_snd_sequencer;

  localparam int U  = 10;
  localparam int G  = 2;
  localparam int QD = 4;

  localparam logic [3:0] C4 = 4'd1, D4 = 4'd2, E4 = 4'd3, F4 = 4'd4,
                         G4 = 4'd5, A4 = 4'd6, C5 = 4'd8, RS = 4'd0;

  logic clk_1mhz = 1'b0;
  always #5 clk_1mhz = ~clk_1mhz;

  logic       rst;
  logic       req_valid, req_prio, req_ready, playing, done_pulse, drop_pulse;
  logic [2:0] req_song, q_count;
  logic [3:0] note_out;

  logic       b_valid, b_prio, b_ready, b_playing, b_done, b_drop;
  logic [3:0] b_song, b_note;
  logic [2:0] b_count;

  snd_sequencer #(.UNIT_CYCLES(U), .GAP_CYCLES(G), .SONG_W(3), .MAX_LEN(8), .QDEPTH(QD)) dut (
    .clk_1mhz(clk_1mhz), .rst(rst), .req_valid(req_valid), .req_song(req_song),
    .req_prio(req_prio), .req_ready(req_ready), .note_out(note_out), .playing(playing),
    .done_pulse(done_pulse), .drop_pulse(drop_pulse), .q_count(q_count));

  snd_sequencer #(.UNIT_CYCLES(U), .GAP_CYCLES(0), .SONG_W(4), .MAX_LEN(8), .QDEPTH(QD)) dut_b (
    .clk_1mhz(clk_1mhz), .rst(rst), .req_valid(b_valid), .req_song(b_song),
    .req_prio(b_prio), .req_ready(b_ready), .note_out(b_note), .playing(b_playing),
    .done_pulse(b_done), .drop_pulse(b_drop), .q_count(b_count));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 100) $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Song table as listened to: per song, a list of (note, units).
  logic [3:0] rom_note [8][8];
  int         rom_dur  [8][8];
  int         rom_len  [8];

  task automatic add(input int s, input logic [3:0] n, input int d);
    rom_note[s][rom_len[s]] = n;
    rom_dur[s][rom_len[s]]  = d;
    rom_len[s]++;
  endtask

  // Reference model: a song becomes a timeline of per-clock (note, playing)
  // slots; the clock after the timeline runs out is the song's end.
  typedef struct { logic [3:0] note; logic play; } slot_t;
  int    m_fifo[$];
  slot_t m_sched[$];
  bit    m_busy;
  logic [3:0] e_note;
  logic  e_play, e_done, e_drop;

  function automatic void m_start(input int s);
    slot_t e;
    logic [3:0] prev;
    prev = RS;
    m_sched.delete();
    for (int i = 0; i < rom_len[s]; i++) begin
      e.note = (i > 0 && G == 0) ? prev : RS;  // one load clock per note
      e.play = (i > 0);
      m_sched.push_back(e);
      for (int k = 0; k < (rom_dur[s][i] + 1) * U; k++) begin
        e.note = rom_note[s][i]; e.play = 1'b1; m_sched.push_back(e);
      end
      for (int k = 0; k < G; k++) begin
        e.note = RS; e.play = 1'b1; m_sched.push_back(e);
      end
      prev = rom_note[s][i];
    end
    m_busy = 1'b1;
  endfunction

  function automatic void m_step(input logic v, input int s, input logic p);
    bit stop, pr, nm, full;
    slot_t cur;
    stop = v && s == 0;
    pr   = v && p && s != 0;
    nm   = v && !p && s != 0;
    full = (m_fifo.size() == QD);
    cur.note = RS; cur.play = 1'b0;
    e_done = 1'b0;
    e_drop = nm && full;
    if (m_busy && m_sched.size() > 0) begin
      cur = m_sched.pop_front();
    end else begin
      if (m_busy) begin e_done = 1'b1; m_busy = 1'b0; end
      if (m_fifo.size() > 0) begin
        m_start(m_fifo.pop_front());
        cur = m_sched.pop_front();
      end
    end
    if (stop) begin
      m_fifo.delete(); m_sched.delete(); m_busy = 1'b0;
      cur.note = RS; cur.play = 1'b0;
    end else if (pr) begin
      m_fifo.delete();
      m_start(s);
      cur = m_sched.pop_front();
    end
    if (nm && !full) m_fifo.push_back(s);
    e_note = cur.note;
    e_play = cur.play;
  endfunction

  task automatic tick(input logic v, input logic [2:0] s, input logic p);
    req_valid = v; req_song = s; req_prio = p;
    @(posedge clk_1mhz);
    @(negedge clk_1mhz);
    req_valid = 1'b0; req_song = 3'd0; req_prio = 1'b0;
  endtask

  task automatic tick_b(input logic v, input logic [3:0] s, input logic p);
    b_valid = v; b_song = s; b_prio = p;
    @(posedge clk_1mhz);
    @(negedge clk_1mhz);
    b_valid = 1'b0; b_song = 4'd0; b_prio = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; req_song = 3'd0; req_prio = 1'b0;
    b_valid = 1'b0; b_song = 4'd0; b_prio = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk_1mhz);
    @(negedge clk_1mhz);
    rst = 1'b0;
    m_fifo.delete(); m_sched.delete(); m_busy = 1'b0;
  endtask

  // Holds for len idle clocks and checks that note/playing stay constant.
  task automatic run_chk(input bit use_b, input string name, input logic [3:0] n,
                         input logic pl, input int len);
    int ok = 0;
    for (int k = 0; k < len; k++) begin
      if (use_b) begin
        tick_b(1'b0, 4'd0, 1'b0);
        if (b_note == n && b_playing == pl && !b_done) ok++;
      end else begin
        tick(1'b0, 3'd0, 1'b0);
        if (note_out == n && playing == pl && !done_pulse) ok++;
      end
    end
    chk(name, ok, len);
  endtask

  task automatic mstep(input int cyc, input logic v, input logic [2:0] s, input logic p);
    m_step(v, int'(s), p);
    tick(v, s, p);
    chk($sformatf("c%0d note", cyc), note_out, e_note);
    chk($sformatf("c%0d playing", cyc), playing, e_play);
    chk($sformatf("c%0d done", cyc), done_pulse, e_done);
    chk($sformatf("c%0d drop", cyc), drop_pulse, e_drop);
    chk($sformatf("c%0d q_count", cyc), q_count, m_fifo.size());
    chk($sformatf("c%0d ready", cyc), req_ready, (m_fifo.size() != QD));
  endtask

  typedef struct {
    logic v; logic [2:0] s; logic p;
    logic [3:0] note; logic play; logic done; logic drop; logic [2:0] cnt; logic rdy;
  } vec_t;
  vec_t vecs [16];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dones;
    for (int s = 0; s < 8; s++) rom_len[s] = 0;
    add(1, D4, 0);
    add(2, C5, 1);
    add(3, C4, 0); add(3, G4, 0);
    add(4, E4, 0); add(4, RS, 0); add(4, E4, 0);
    add(5, C4, 0); add(5, E4, 0); add(5, G4, 0); add(5, C5, 1);
    add(6, C5, 0); add(6, G4, 0); add(6, E4, 0); add(6, C4, 2);
    add(7, C4, 0); add(7, E4, 0); add(7, G4, 0); add(7, RS, 0);
    add(7, F4, 0); add(7, A4, 0); add(7, C5, 3);

    //            v  s  p   note play done drop cnt rdy
    vecs[0]  = '{1, 7, 0,  RS, 0, 0, 0, 1, 1};
    vecs[1]  = '{1, 1, 0,  RS, 0, 0, 0, 1, 1};
    vecs[2]  = '{1, 2, 0,  C4, 1, 0, 0, 2, 1};
    vecs[3]  = '{1, 3, 0,  C4, 1, 0, 0, 3, 1};
    vecs[4]  = '{1, 4, 0,  C4, 1, 0, 0, 4, 0};
    vecs[5]  = '{1, 5, 0,  C4, 1, 0, 1, 4, 0};
    vecs[6]  = '{0, 0, 0,  C4, 1, 0, 0, 4, 0};
    vecs[7]  = '{1, 6, 1,  RS, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 0,  C5, 1, 0, 0, 0, 1};
    vecs[9]  = '{1, 0, 0,  RS, 0, 0, 0, 0, 1};
    vecs[10] = '{0, 0, 0,  RS, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 2, 0,  RS, 0, 0, 0, 1, 1};
    vecs[12] = '{0, 0, 0,  RS, 0, 0, 0, 0, 1};
    vecs[13] = '{0, 0, 0,  C5, 1, 0, 0, 0, 1};
    vecs[14] = '{1, 0, 1,  RS, 0, 0, 0, 0, 1};
    vecs[15] = '{0, 0, 0,  RS, 0, 0, 0, 0, 1};

    // Reset state
    do_reset();
    chk("reset note", note_out, 0);
    chk("reset playing", playing, 0);
    chk("reset done", done_pulse, 0);
    chk("reset drop", drop_pulse, 0);
    chk("reset q_count", q_count, 0);
    chk("reset ready", req_ready, 1);
    chk("reset b ready", b_ready, 1);
    chk("reset b drop", b_drop, 0);
    $display("reset checked");

    // Queue fill, drop, priority pre-empt, stop (both prio values)
    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].v, vecs[i].s, vecs[i].p);
      $display("vec %0d valid=%0d song=%0d prio=%0d note=%0d q=%0d", i,
               vecs[i].v, vecs[i].s, vecs[i].p, note_out, q_count);
      chk($sformatf("vec%0d note", i), note_out, vecs[i].note);
      chk($sformatf("vec%0d playing", i), playing, vecs[i].play);
      chk($sformatf("vec%0d done", i), done_pulse, vecs[i].done);
      chk($sformatf("vec%0d drop", i), drop_pulse, vecs[i].drop);
      chk($sformatf("vec%0d q_count", i), q_count, vecs[i].cnt);
      chk($sformatf("vec%0d ready", i), req_ready, vecs[i].rdy);
    end

    // Song 3: C4, silence (gap + load clock), G4, gap, done
    do_reset();
    tick(1'b1, 3'd3, 1'b0);
    chk("t1 q_count", q_count, 1);
    tick(1'b0, 3'd0, 1'b0);
    chk("t1 load note", note_out, 0);
    chk("t1 load playing", playing, 0);
    run_chk(1'b0, "t1 C4 run", C4, 1'b1, 10);
    run_chk(1'b0, "t1 gap1 run", RS, 1'b1, 3);
    run_chk(1'b0, "t1 G4 run", G4, 1'b1, 10);
    run_chk(1'b0, "t1 gap2 run", RS, 1'b1, 2);
    tick(1'b0, 3'd0, 1'b0);
    chk("t1 done", done_pulse, 1);
    chk("t1 end playing", playing, 0);
    tick(1'b0, 3'd0, 1'b0);
    chk("t1 done one clock", done_pulse, 0);
    $display("song 3 sequence checked");

    // Song 4: the rest entry keeps playing high
    do_reset();
    tick(1'b1, 3'd4, 1'b0);
    tick(1'b0, 3'd0, 1'b0);
    run_chk(1'b0, "t6 E4 run a", E4, 1'b1, 10);
    run_chk(1'b0, "t6 rest run", RS, 1'b1, 16);
    run_chk(1'b0, "t6 E4 run b", E4, 1'b1, 10);
    run_chk(1'b0, "t6 tail gap", RS, 1'b1, 2);
    tick(1'b0, 3'd0, 1'b0);
    chk("t6 done", done_pulse, 1);
    $display("song 4 sequence checked");

    // Asynchronous reset in the middle of song 5 with a queued request
    do_reset();
    tick(1'b1, 3'd5, 1'b0);
    tick(1'b0, 3'd0, 1'b0);
    run_chk(1'b0, "t5 C4 part", C4, 1'b1, 5);
    tick(1'b1, 3'd3, 1'b0);
    chk("t5 queued", q_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5 async note", note_out, 0);
    chk("t5 async playing", playing, 0);
    chk("t5 async q_count", q_count, 0);
    chk("t5 async ready", req_ready, 1);
    @(negedge clk_1mhz);
    rst = 1'b0;
    tick(1'b0, 3'd0, 1'b0);
    tick(1'b0, 3'd0, 1'b0);
    chk("t5 after reset playing", playing, 0);
    chk("t5 after reset q_count", q_count, 0);
    $display("mid-song reset checked");

    // Songs 1, 2, 5 back to back against the model
    do_reset();
    dones = 0;
    mstep(0, 1'b1, 3'd1, 1'b0);
    mstep(1, 1'b1, 3'd2, 1'b0);
    mstep(2, 1'b1, 3'd5, 1'b0);
    for (int c = 3; c < 110; c++) begin
      mstep(c, 1'b0, 3'd0, 1'b0);
      if (done_pulse) dones++;
    end
    chk("t2 done count", dones, 3);
    $display("back-to-back songs checked");

    // Random requests against the model
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      int r;
      logic v, p;
      logic [2:0] s;
      r = $urandom_range(0, 99);
      v = 1'b0; p = 1'b0; s = 3'd0;
      if (r < 10) begin
        v = 1'b1; s = 3'($urandom_range(1, 7));
      end else if (r < 12) begin
        v = 1'b1; p = 1'b1; s = 3'($urandom_range(1, 7));
      end else if (r < 13) begin
        v = 1'b1; p = 1'($urandom_range(0, 1)); s = 3'd0;
      end
      if (v) $display("req cycle=%0d song=%0d prio=%0d", c, s, p);
      mstep(c, v, s, p);
    end

    // Unused id and a single-note song with no gap state
    do_reset();
    tick_b(1'b1, 4'd9, 1'b0);
    chk("b q_count", b_count, 1);
    tick_b(1'b0, 4'd0, 1'b0);
    chk("b load playing", b_playing, 0);
    run_chk(1'b1, "b unused silent unit", RS, 1'b1, 10);
    tick_b(1'b0, 4'd0, 1'b0);
    chk("b unused done", b_done, 1);
    chk("b unused end playing", b_playing, 0);
    tick_b(1'b1, 4'd2, 1'b0);
    tick_b(1'b0, 4'd0, 1'b0);
    run_chk(1'b1, "b C5 run", C5, 1'b1, 20);
    tick_b(1'b0, 4'd0, 1'b0);
    chk("b song2 done", b_done, 1);
    chk("b song2 note", b_note, 0);
    $display("no-gap instance checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
